// File: rtl/sub8_serial_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package sub8_serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sub8_serial_if.sv
// Request/result bundle between a requester (master) and the serial subtractor (slave).
interface sub8_serial_if
  import sub8_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bi;
  logic             busy;
  logic             done;
  logic             bo;
  logic [WIDTH-1:0] d;

  modport master (output start, a, b, bi, input busy, done, bo, d);
  modport slave  (input start, a, b, bi, output busy, done, bo, d);

endinterface

// File: rtl/sub8_serial_fsub1.sv
// One-bit full subtractor: diff = x - y - bin, bout set when the column borrows.
module sub8_serial_fsub1 (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/sub8_serial.sv
// Bit-serial subtractor d = a - b - bi, one bit per clock LSB first, with a done pulse.
module sub8_serial
  import sub8_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic          clk,
  input logic          rst_n,
  sub8_serial_if.slave bus
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  state_e           state_r;
  logic [WIDTH-1:0] ra_r;
  logic [WIDTH-1:0] rb_r;
  logic [WIDTH-1:0] rd_r;
  logic [WIDTH-1:0] d_r;
  logic [CNT_W-1:0] cnt_r;
  logic             br_r;
  logic             bo_r;
  logic             busy_r;
  logic             done_r;
  logic             diff_s;
  logic             bout_s;
  logic [WIDTH-1:0] rd_next_s;

  sub8_serial_fsub1 u_fsub1 (
    .x    (ra_r[0]),
    .y    (rb_r[0]),
    .bin  (br_r),
    .diff (diff_s),
    .bout (bout_s)
  );

  assign rd_next_s = {diff_s, rd_r[WIDTH-1:1]};

  // Control FSM, operand/result shift registers, borrow flop and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      ra_r    <= {WIDTH{1'b0}};
      rb_r    <= {WIDTH{1'b0}};
      rd_r    <= {WIDTH{1'b0}};
      d_r     <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      br_r    <= 1'b0;
      bo_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        // DONE accepts a new start exactly like IDLE, giving back-to-back operation.
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            ra_r    <= bus.a;
            rb_r    <= bus.b;
            br_r    <= bus.bi;
            rd_r    <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          ra_r  <= {1'b0, ra_r[WIDTH-1:1]};
          rb_r  <= {1'b0, rb_r[WIDTH-1:1]};
          rd_r  <= rd_next_s;
          br_r  <= bout_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            d_r     <= rd_next_s;
            bo_r    <= bout_s;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            state_r <= ST_RUN;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.bo   = bo_r;
  assign bus.d    = d_r;

endmodule
